// File: rtl/sram_fifo_core_gen2_if.sv
// rtl/sram_fifo_core_gen2_if.sv - register bus, upstream FIFO, output stream, SRAM and status signals of the FIFO core
interface sram_fifo_core_gen2_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int SRAM_WIDTH = 16,
  parameter int IN_WIDTH   = 32
);
  logic [15:0]           BUS_ADD;
  logic [7:0]            BUS_DATA_IN;
  logic [7:0]            BUS_DATA_OUT;
  logic                  BUS_RD;
  logic                  BUS_WR;
  logic [ADDR_WIDTH-1:0] SRAM_A;
  logic [SRAM_WIDTH-1:0] SRAM_IO_IN;
  logic [SRAM_WIDTH-1:0] SRAM_IO_OUT;
  logic                  SRAM_IO_OE;
  logic                  SRAM_BHE_B;
  logic                  SRAM_BLE_B;
  logic                  SRAM_CE1_B;
  logic                  SRAM_OE_B;
  logic                  SRAM_WE_B;
  logic                  FIFO_READ_NEXT_OUT;
  logic                  FIFO_EMPTY_IN;
  logic [IN_WIDTH-1:0]   FIFO_DATA;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic [SRAM_WIDTH-1:0] OUT_DATA;
  logic                  FIFO_NOT_EMPTY;
  logic                  FIFO_FULL;
  logic                  FIFO_NEAR_FULL;
  logic                  FIFO_READ_ERROR;

  modport slave (
    input  BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, SRAM_IO_IN, FIFO_EMPTY_IN, FIFO_DATA, OUT_READY,
    output BUS_DATA_OUT, SRAM_A, SRAM_IO_OUT, SRAM_IO_OE, SRAM_BHE_B, SRAM_BLE_B, SRAM_CE1_B,
           SRAM_OE_B, SRAM_WE_B, FIFO_READ_NEXT_OUT, OUT_VALID, OUT_DATA, FIFO_NOT_EMPTY,
           FIFO_FULL, FIFO_NEAR_FULL, FIFO_READ_ERROR
  );

  modport master (
    output BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, SRAM_IO_IN, FIFO_EMPTY_IN, FIFO_DATA, OUT_READY,
    input  BUS_DATA_OUT, SRAM_A, SRAM_IO_OUT, SRAM_IO_OE, SRAM_BHE_B, SRAM_BLE_B, SRAM_CE1_B,
           SRAM_OE_B, SRAM_WE_B, FIFO_READ_NEXT_OUT, OUT_VALID, OUT_DATA, FIFO_NOT_EMPTY,
           FIFO_FULL, FIFO_NEAR_FULL, FIFO_READ_ERROR
  );
endinterface

// File: rtl/sram_fifo_core_gen2.sv
// rtl/sram_fifo_core_gen2.sv - SRAM ring-buffer FIFO packing upstream words into SRAM words
// Optional peak-count registers 6..8 are built only when SRAM_FIFO_PEAK_EN is defined.
module sram_fifo_core_gen2 #(
  parameter int ADDR_WIDTH    = 20,
  parameter int SRAM_WIDTH    = 16,
  parameter int IN_WIDTH      = 32,
  parameter int NEAR_FULL_PCT = 95
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  sram_fifo_core_gen2_if.slave bus
);
  localparam int R  = IN_WIDTH / SRAM_WIDTH;
  localparam int SW = $clog2(R + 1);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int NW = ADDR_WIDTH + 8;
  localparam logic [CW-1:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [6:0]    THR_RST = 7'(NEAR_FULL_PCT);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_LATCH, WR_ADDR, WR_PULSE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [IN_WIDTH-1:0]   hold_q, hold_d;
  logic [SW-1:0]         slices_q, slices_d;
  logic                  out_valid_q, out_valid_d;
  logic [SRAM_WIDTH-1:0] out_data_q, out_data_d;
  logic                  near_full_q, near_full_d;
  logic                  read_error_q, read_error_d;
  logic [6:0]            thr_q, thr_d;
  logic [15:0]           cnt_hi_q, cnt_hi_d;
  logic [7:0]            bus_data_out_q, bus_data_out_d;
  logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
  logic [SRAM_WIDTH-1:0] sram_io_out_q, sram_io_out_d;
  logic                  sram_io_oe_q, sram_io_oe_d;
  logic                  sram_ce_b_q, sram_ce_b_d;
  logic                  sram_oe_b_q, sram_oe_b_d;
  logic                  sram_we_b_q, sram_we_b_d;
`ifdef SRAM_FIFO_PEAK_EN
  logic [CW-1:0]         peak_q, peak_d;
  logic [15:0]           peak_hi_q, peak_hi_d;
  logic [23:0]           peak_ext;
  assign peak_ext = 24'(peak_q);
`endif

  logic        soft_rst, pop, out_fire, full;
  logic [23:0] count_ext;

  assign full      = (count_q == DEPTH);
  assign soft_rst  = bus.BUS_WR && (bus.BUS_ADD == 16'd0);
  assign pop       = (slices_q == '0) && !bus.FIFO_EMPTY_IN && !soft_rst;
  assign out_fire  = out_valid_q && bus.OUT_READY;
  assign count_ext = 24'(count_q);

  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    hold_d         = hold_q;
    slices_d       = slices_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    read_error_d   = read_error_q;
    thr_d          = thr_q;
    cnt_hi_d       = cnt_hi_q;
    bus_data_out_d = 8'd0;
    near_full_d    = (NW'(count_q) * NW'(100)) >= (NW'(thr_q) << ADDR_WIDTH);
`ifdef SRAM_FIFO_PEAK_EN
    peak_d         = (count_q > peak_q) ? count_q : peak_q;
    peak_hi_d      = peak_hi_q;
`endif

    if (out_fire)                         out_valid_d  = 1'b0;
    if (bus.OUT_READY && !out_valid_q)    read_error_d = 1'b1;
    if (pop) begin
      hold_d   = bus.FIFO_DATA;
      slices_d = SW'(R);
    end

    // Reads win arbitration so the output register refills as soon as it drains
    case (state_q)
      IDLE: begin
        if ((!out_valid_q || out_fire) && count_q != '0) state_d = RD_ADDR;
        else if (slices_q != '0 && !full)                state_d = WR_ADDR;
      end
      RD_ADDR:  state_d = RD_LATCH;
      RD_LATCH: begin
        state_d     = IDLE;
        out_data_d  = bus.SRAM_IO_IN;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        count_d     = count_q - CW'(1);
      end
      WR_ADDR:  state_d = WR_PULSE;
      WR_PULSE: begin
        state_d  = IDLE;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        count_d  = count_q + CW'(1);
        hold_d   = hold_q >> SRAM_WIDTH;
        slices_d = slices_q - SW'(1);
      end
      default:  state_d = IDLE;
    endcase

    if (bus.BUS_RD) begin
      case (bus.BUS_ADD)
        16'd0: bus_data_out_d = 8'd2;
        16'd1: begin
          bus_data_out_d = count_ext[7:0];
          cnt_hi_d       = count_ext[23:8];
        end
        16'd2: bus_data_out_d = cnt_hi_q[7:0];
        16'd3: bus_data_out_d = cnt_hi_q[15:8];
        16'd4: bus_data_out_d = {1'b0, thr_q};
        16'd5: bus_data_out_d = {5'b0, read_error_q, full, near_full_q};
`ifdef SRAM_FIFO_PEAK_EN
        16'd6: begin
          bus_data_out_d = peak_ext[7:0];
          peak_hi_d      = peak_ext[23:8];
        end
        16'd7: bus_data_out_d = peak_hi_q[7:0];
        16'd8: bus_data_out_d = peak_hi_q[15:8];
`endif
        default: bus_data_out_d = 8'd0;
      endcase
    end

    if (bus.BUS_WR && bus.BUS_ADD == 16'd4 && bus.BUS_DATA_IN != 8'd0 && bus.BUS_DATA_IN <= 8'd100)
      thr_d = bus.BUS_DATA_IN[6:0];
`ifdef SRAM_FIFO_PEAK_EN
    if (bus.BUS_WR && bus.BUS_ADD == 16'd6) peak_d = '0;
`endif

    if (soft_rst) begin
      state_d      = IDLE;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      hold_d       = '0;
      slices_d     = '0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      near_full_d  = 1'b0;
      read_error_d = 1'b0;
      thr_d        = THR_RST;
`ifdef SRAM_FIFO_PEAK_EN
      peak_d       = '0;
`endif
    end

    // SRAM pins are registered from the next state, so a soft reset releases WE_B/OE_B on the same edge
    sram_ce_b_d   = 1'b1;
    sram_oe_b_d   = 1'b1;
    sram_we_b_d   = 1'b1;
    sram_io_oe_d  = 1'b0;
    sram_a_d      = sram_a_q;
    sram_io_out_d = sram_io_out_q;
    case (state_d)
      RD_ADDR, RD_LATCH: begin
        sram_ce_b_d = 1'b0;
        sram_oe_b_d = 1'b0;
        sram_a_d    = rd_ptr_d;
      end
      WR_ADDR, WR_PULSE: begin
        sram_ce_b_d   = 1'b0;
        sram_io_oe_d  = 1'b1;
        sram_we_b_d   = (state_d != WR_PULSE);
        sram_a_d      = wr_ptr_d;
        sram_io_out_d = hold_d[SRAM_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q        <= IDLE;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      hold_q         <= '0;
      slices_q       <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      near_full_q    <= 1'b0;
      read_error_q   <= 1'b0;
      thr_q          <= THR_RST;
      cnt_hi_q       <= '0;
      bus_data_out_q <= '0;
      sram_a_q       <= '0;
      sram_io_out_q  <= '0;
      sram_io_oe_q   <= 1'b0;
      sram_ce_b_q    <= 1'b1;
      sram_oe_b_q    <= 1'b1;
      sram_we_b_q    <= 1'b1;
`ifdef SRAM_FIFO_PEAK_EN
      peak_q         <= '0;
      peak_hi_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      hold_q         <= hold_d;
      slices_q       <= slices_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      near_full_q    <= near_full_d;
      read_error_q   <= read_error_d;
      thr_q          <= thr_d;
      cnt_hi_q       <= cnt_hi_d;
      bus_data_out_q <= bus_data_out_d;
      sram_a_q       <= sram_a_d;
      sram_io_out_q  <= sram_io_out_d;
      sram_io_oe_q   <= sram_io_oe_d;
      sram_ce_b_q    <= sram_ce_b_d;
      sram_oe_b_q    <= sram_oe_b_d;
      sram_we_b_q    <= sram_we_b_d;
`ifdef SRAM_FIFO_PEAK_EN
      peak_q         <= peak_d;
      peak_hi_q      <= peak_hi_d;
`endif
    end
  end

  assign bus.BUS_DATA_OUT       = bus_data_out_q;
  assign bus.SRAM_A             = sram_a_q;
  assign bus.SRAM_IO_OUT        = sram_io_out_q;
  assign bus.SRAM_IO_OE         = sram_io_oe_q;
  assign bus.SRAM_BHE_B         = 1'b0;
  assign bus.SRAM_BLE_B         = 1'b0;
  assign bus.SRAM_CE1_B         = sram_ce_b_q;
  assign bus.SRAM_OE_B          = sram_oe_b_q;
  assign bus.SRAM_WE_B          = sram_we_b_q;
  assign bus.FIFO_READ_NEXT_OUT = pop;
  assign bus.OUT_VALID          = out_valid_q;
  assign bus.OUT_DATA           = out_data_q;
  assign bus.FIFO_NOT_EMPTY     = (count_q != '0) || out_valid_q;
  assign bus.FIFO_FULL          = full;
  assign bus.FIFO_NEAR_FULL     = near_full_q;
  assign bus.FIFO_READ_ERROR    = read_error_q;
endmodule
